// File: rtl/adder_io_pkg.sv
// Shared definitions for the ASCII operand front end of the 5-bit adder.
//   ASCII_*   : byte values recognised by the parser
//   state_t   : parser FSM states
//   err_t     : error codes reported on err_code
//   SEL_X/Y   : operand selector values (also the err_sel encoding)
package adder_io_pkg;

   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_9  = 8'h39;

   localparam logic SEL_X = 1'b0;
   localparam logic SEL_Y = 1'b1;

   typedef enum logic [2:0] {
      D1,
      D2,
      EOL,
      FLUSH,
      HOLD
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_NONDIGIT,
      ERR_RANGE,
      ERR_LONG
   } err_t;

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational classifier for one ASCII byte.
//   char_in  : byte under test
//   is_digit : byte is '0'..'9'
//   is_lf    : byte is line feed
//   digit    : numeric value of the digit (0 when not a digit)
module ascii_digit_decode
   import adder_io_pkg::*;
(
   input  logic [7:0] char_in,
   output logic       is_digit,
   output logic       is_lf,
   output logic [3:0] digit
);

   assign is_digit = (char_in >= ASCII_0) && (char_in <= ASCII_9);
   assign is_lf    = (char_in == ASCII_LF);
   // '0'..'9' are 0x30..0x39, so the low nibble is already the value.
   assign digit    = is_digit ? char_in[3:0] : 4'd0;

endmodule

// File: rtl/ascii_operand_loader.sv
// Parses two LF-terminated ASCII decimal operands (X then Y, 0..MAX_VAL)
// from a valid/ready byte stream and presents them to the 5-bit adder,
// holding the pair until acknowledged.
//   clk, rst            : clock, asynchronous active-high reset
//   char_in/char_valid  : byte stream input
//   char_ready          : byte accepted when char_valid && char_ready
//   x, y                : parsed operands for the adder
//   op_valid / op_ack   : pair complete / consumer took the pair
//   err_valid           : one-cycle error pulse
//   err_code, err_sel   : error type and operand in error (0 = X, 1 = Y)
module ascii_operand_loader
   import adder_io_pkg::*;
#(
   parameter int MAX_VAL = 31
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   output logic [4:0] x,
   output logic [4:0] y,
   output logic       op_valid,
   input  logic       op_ack,
   output logic       err_valid,
   output logic [1:0] err_code,
   output logic       err_sel
);

   state_t     state_reg, state_next;
   logic       sel_reg, sel_next;
   logic [3:0] d1_reg;
   logic [4:0] val_reg;
   logic [4:0] x_reg, y_reg;
   logic       err_valid_reg;
   err_t       err_code_reg;
   logic       err_sel_reg;

   logic       is_digit, is_lf;
   logic [3:0] digit;
   logic       accept;
   logic [6:0] v_wide;

   // control strobes from the next-state logic to the datapath
   logic       latch_d1, latch_v, load, err_set;
   err_t       err_type;
   logic [4:0] load_val;

   ascii_digit_decode u_decode (
      .char_in  (char_in),
      .is_digit (is_digit),
      .is_lf    (is_lf),
      .digit    (digit)
   );

   assign accept = char_valid && char_ready;
   // Two-digit value, wide enough for "99" so the range test is exact.
   assign v_wide = 7'(d1_reg) * 7'd10 + 7'(digit);

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= D1;
         sel_reg   <= SEL_X;
      end else begin
         state_reg <= state_next;
         sel_reg   <= sel_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      sel_next   = sel_reg;
      latch_d1   = 1'b0;
      latch_v    = 1'b0;
      load       = 1'b0;
      load_val   = val_reg;
      err_set    = 1'b0;
      err_type   = ERR_NONE;

      case (state_reg)
         D1: begin
            if (accept) begin
               if (is_digit) begin
                  latch_d1   = 1'b1;
                  state_next = D2;
               end else if (is_lf) begin
                  // empty line: nothing to flush, stay put
                  err_set  = 1'b1;
                  err_type = ERR_NONDIGIT;
               end else begin
                  err_set    = 1'b1;
                  err_type   = ERR_NONDIGIT;
                  state_next = FLUSH;
               end
            end
         end
         D2: begin
            if (accept) begin
               if (is_lf) begin
                  load     = 1'b1;
                  load_val = {1'b0, d1_reg};
               end else if (is_digit) begin
                  if (v_wide > 7'(MAX_VAL)) begin
                     err_set    = 1'b1;
                     err_type   = ERR_RANGE;
                     state_next = FLUSH;
                  end else begin
                     latch_v    = 1'b1;
                     state_next = EOL;
                  end
               end else begin
                  err_set    = 1'b1;
                  err_type   = ERR_NONDIGIT;
                  state_next = FLUSH;
               end
            end
         end
         EOL: begin
            if (accept) begin
               if (is_lf) begin
                  load = 1'b1;
               end else begin
                  err_set    = 1'b1;
                  err_type   = ERR_LONG;
                  state_next = FLUSH;
               end
            end
         end
         FLUSH: begin
            // same operand is retried; sel is left alone
            if (accept && is_lf) begin
               state_next = D1;
            end
         end
         HOLD: begin
            if (op_ack) begin
               state_next = D1;
               sel_next   = SEL_X;
            end
         end
         default: begin
            state_next = D1;
         end
      endcase

      if (load) begin
         if (sel_reg == SEL_X) begin
            sel_next   = SEL_Y;
            state_next = D1;
         end else begin
            state_next = HOLD;
         end
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      op_valid   = 1'b0;
      char_ready = 1'b1;
      if (state_reg == HOLD) begin
         op_valid   = 1'b1;
         char_ready = 1'b0;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d1_reg        <= 4'd0;
         val_reg       <= 5'd0;
         x_reg         <= 5'd0;
         y_reg         <= 5'd0;
         err_valid_reg <= 1'b0;
         err_code_reg  <= ERR_NONE;
         err_sel_reg   <= SEL_X;
      end else begin
         if (latch_d1) begin
            d1_reg <= digit;
         end
         if (latch_v) begin
            val_reg <= v_wide[4:0];
         end
         if (load && (sel_reg == SEL_X)) begin
            x_reg <= load_val;
         end
         if (load && (sel_reg == SEL_Y)) begin
            y_reg <= load_val;
         end
         err_valid_reg <= err_set;
         if (err_set) begin
            err_code_reg <= err_type;
            err_sel_reg  <= sel_reg;
         end
      end
   end

   assign x         = x_reg;
   assign y         = y_reg;
   assign err_valid = err_valid_reg;
   assign err_code  = err_code_reg;
   assign err_sel   = err_sel_reg;

endmodule

// File: tb/tb_ascii_operand_loader.sv
// Testbench for ascii_operand_loader: directed lines from the test plan
// followed by random lines, checked against a line-level parsing model.
module tb_ascii_operand_loader;

   logic       clk;
   logic       rst;
   logic [7:0] char_in;
   logic       char_valid;
   logic       char_ready;
   logic [4:0] x;
   logic [4:0] y;
   logic       op_valid;
   logic       op_ack;
   logic       err_valid;
   logic [1:0] err_code;
   logic       err_sel;

   int n_assert = 0;
   int n_fail   = 0;

   // model state
   int exp_x   = 0;
   int exp_y   = 0;
   int exp_sel = 0;

   // error pulse monitor
   int         err_cnt  = 0;
   logic [1:0] last_code = 2'd0;
   logic       last_sel  = 1'b0;

   ascii_operand_loader #(.MAX_VAL(31)) dut (
      .clk        (clk),
      .rst        (rst),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .x          (x),
      .y          (y),
      .op_valid   (op_valid),
      .op_ack     (op_ack),
      .err_valid  (err_valid),
      .err_code   (err_code),
      .err_sel    (err_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (err_valid === 1'b1) begin
         err_cnt++;
         last_code = err_code;
         last_sel  = err_sel;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Reference: outcome of one line (bytes before LF). Returns 0 for a
   // legal operand (value in val) or the error code the line produces.
   function automatic int classify(input string s, output int val);
      int n;
      int c0;
      int c1;
      int v;
      n   = s.len();
      val = 0;
      if (n == 0) return 1;
      c0 = int'(s[0]) - 48;
      if (c0 < 0 || c0 > 9) return 1;
      if (n == 1) begin
         val = c0;
         return 0;
      end
      c1 = int'(s[1]) - 48;
      if (c1 < 0 || c1 > 9) return 1;
      v = c0 * 10 + c1;
      if (v > 31) return 2;
      if (n >= 3) return 3;
      val = v;
      return 0;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      char_in    = b;
      char_valid = 1'b1;
      while (char_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (char_ready !== 1'b1) begin
         chk("accept_timeout", char_ready, 1);
         char_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         char_valid = 1'b0;
      end
   endtask

   task automatic do_hold(input int k);
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         char_valid = 1'b1;
         char_in    = 8'h39;
         #1;
         chk("hold_ready", char_ready, 0);
      end
      @(negedge clk);
      char_valid = 1'b0;
      #1;
      chk("hold_op_valid", op_valid, 1);
      chk("hold_x", x, exp_x);
      chk("hold_y", y, exp_y);
   endtask

   task automatic do_ack();
      @(negedge clk);
      op_ack = 1'b1;
      @(posedge clk);
      #1;
      op_ack = 1'b0;
      chk("ack_op_valid", op_valid, 0);
      chk("ack_ready", char_ready, 1);
   endtask

   task automatic run_line(input string s, input int hold_cycles, input bit auto_ack);
      int e0;
      int code;
      int v;
      int sel_before;
      bit loaded_y;
      e0         = err_cnt;
      sel_before = exp_sel;
      loaded_y   = 1'b0;
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
      send_byte(8'h0A);
      @(negedge clk);
      #1;
      code = classify(s, v);
      if (code == 0) begin
         if (exp_sel == 0) begin
            exp_x   = v;
            exp_sel = 1;
         end else begin
            exp_y    = v;
            loaded_y = 1'b1;
         end
      end
      chk($sformatf("err_count[%s]", s), err_cnt - e0, (code == 0) ? 0 : 1);
      if (code != 0) begin
         chk($sformatf("err_code[%s]", s), last_code, code);
         chk($sformatf("err_sel[%s]", s), last_sel, sel_before);
      end
      chk($sformatf("x[%s]", s), x, exp_x);
      chk($sformatf("y[%s]", s), y, exp_y);
      chk($sformatf("op_valid[%s]", s), op_valid, loaded_y);
      @(negedge clk);
      #1;
      chk("err_pulse_width", err_valid, 0);
      $display("line \"%s\" -> code %0d x=%0d y=%0d op_valid=%0b", s, code, x, y, op_valid);
      if (loaded_y) begin
         if (hold_cycles > 0) do_hold(hold_cycles);
         if (auto_ack) begin
            do_ack();
            exp_sel = 0;
         end
      end
   endtask

   task automatic model_reset();
      exp_x   = 0;
      exp_y   = 0;
      exp_sel = 0;
   endtask

   function automatic string rand_line();
      string s;
      int    r;
      int    p;
      byte   c;
      s = "";
      r = $urandom_range(0, 9);
      case (r)
         0: s = "";
         1, 9: begin
            if (r == 9) s = $sformatf("%0d", $urandom_range(0, 9));
            p = $urandom_range(0, 3);
            if (p == 0)      c = 8'h2F;
            else if (p == 1) c = 8'h3A;
            else if (p == 2) c = 8'h20;
            else             c = byte'(8'h61 + $urandom_range(0, 25));
            s = $sformatf("%s%c", s, c);
         end
         2, 3, 4: s = $sformatf("%0d", $urandom_range(0, 9));
         5, 6, 7: s = $sformatf("%02d", $urandom_range(0, 45));
         default: s = $sformatf("%03d", $urandom_range(0, 999));
      endcase
      return s;
   endfunction

   initial begin
      rst        = 1'b1;
      char_in    = 8'h00;
      char_valid = 1'b0;
      op_ack     = 1'b0;
      #22;
      chk("rst_op_valid", op_valid, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_err_valid", err_valid, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_err_sel", err_sel, 0);
      chk("rst_ready", char_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      // "12" + "19", ack after 3 held cycles; adder result 31, no carry
      run_line("12", 0, 1'b0);
      run_line("19", 3, 1'b0);
      chk("adder_sum", 6'({1'b0, x} + {1'b0, y}), 31);
      do_ack();
      exp_sel = 0;

      run_line("7", 0, 1'b1);
      run_line("31", 1, 1'b1);

      run_line("32", 0, 1'b1);
      run_line("05", 0, 1'b1);
      run_line("04", 2, 1'b1);

      run_line("123", 0, 1'b1);
      run_line("4", 0, 1'b1);
      run_line("a", 0, 1'b1);
      run_line("", 0, 1'b1);
      run_line("00", 0, 1'b1);

      // op_ack outside HOLD must be ignored
      run_line("9", 0, 1'b1);
      @(negedge clk);
      op_ack = 1'b1;
      @(negedge clk);
      op_ack = 1'b0;
      run_line("30", 0, 1'b1);

      // error pulse in flight is cleared by reset
      send_byte(8'h61);
      chk("err_before_rst", err_valid, 1);
      rst = 1'b1;
      #1;
      chk("err_cleared_by_rst", err_valid, 0);
      chk("err_code_cleared", err_code, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      for (int i = 0; i < 40; i++) begin
         run_line(rand_line(), $urandom_range(0, 3), 1'b1);
      end

      // reset mid-HOLD with a byte pending
      run_line("3", 0, 1'b1);
      run_line("4", 5, 1'b0);
      @(negedge clk);
      char_valid = 1'b1;
      char_in    = 8'h35;
      #2;
      rst = 1'b1;
      #1;
      chk("hold_rst_op_valid", op_valid, 0);
      chk("hold_rst_x", x, 0);
      chk("hold_rst_y", y, 0);
      char_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", char_ready, 1);
      model_reset();
      run_line("5", 0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
